// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- serial receiver with a small show-ahead byte FIFO.
//
// The block deserialises frames arriving on RX and queues good bytes in a FIFO.
// Frames are 8N1 by default, or 8E1 when UART_RX_PARITY_EN is defined.
// Consumers pop bytes with a single-cycle READ strobe.
// Bad stop or parity bits, and bytes lost to a full FIFO, raise sticky flags.
// CLR clears those flags.
//
// Ports:
//   CLOCK    in   system clock
//   RESET_N  in   asynchronous active-low reset
//   RX       in   asynchronous serial line, idle high
//   DATA     out  FIFO head byte (0 while empty)
//   VALID    out  FIFO non-empty
//   READ     in   pop strobe, ignored while empty
//   COUNT    out  bytes held (0..2^DEPTH_LOG2)
//   FERR     out  sticky framing/parity error
//   OVERRUN  out  sticky byte-dropped-on-full
//   CLR      in   clears FERR and OVERRUN (a same-cycle new event wins)
//
// Build option: UART_RX_PARITY_EN -- adds an even-parity bit before the stop bit.

module uart_rx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  RX,
    output logic [7:0]            DATA,
    output logic                  VALID,
    input  logic                  READ,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FERR,
    output logic                  OVERRUN,
    input  logic                  CLR
);

    localparam int BIT   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF  = BIT / 2;
    localparam int CNT_W = $clog2(BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CNT_W-1:0]    HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]    BIT_M1  = CNT_W'(BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL_N  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // RX synchroniser; resets to the idle level so reset never fakes a start
    // ------------------------------------------------------------------
    logic rx_s1, rxs;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rxs   <= rx_s1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             tick;
    logic             push;
    logic             frame_err;

    // cnt is cleared on the start edge (cycle E), so the first sample lands
    // HALF clocks later and each later sample a full BIT after the previous one.
    assign tick = (state == S_START) ? (cnt == HALF_M1) : (cnt == BIT_M1);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_IDLE:  if (!rxs) state_n = S_START;
            S_START: if (tick) state_n = rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            // shreg already holds the full byte here; a mismatch abandons the
            // frame at once and the still-high stop bit looks like idle.
            S_PARITY: begin
                if (tick) begin
                    if (rxs != ^shreg) begin
                        frame_err = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        state_n   = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_n = S_IDLE;
                    if (rxs) push      = 1'b1;
                    else     frame_err = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (state == S_IDLE || tick) cnt <= '0;
            else                         cnt <= cnt + 1'b1;

            if (state == S_START)             idx <= '0;
            else if (state == S_DATA && tick) idx <= idx + 1'b1;

            if (state == S_DATA && tick) shreg <= {rxs, shreg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  pop, full, wr_en, ovf;

    assign VALID = (COUNT != '0);
    assign full  = (COUNT == FULL_N);
    assign pop   = READ && VALID;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign ovf   = push && full && !pop;
    assign DATA  = VALID ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge CLOCK) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags; a new event in the CLR cycle leaves the flag set
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (frame_err) FERR <= 1'b1;
            else if (CLR)  FERR <= 1'b0;

            if (ovf)       OVERRUN <= 1'b1;
            else if (CLR)  OVERRUN <= 1'b0;
        end
    end

endmodule
